// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolution queue: the pipeline PC type and the
// predictor training-update record.
package PipelineTypes;
    localparam int unsigned PC_W = 32;
    typedef logic [PC_W-1:0] pc_t;
endpackage

package BranchResolveTypes;
    import PipelineTypes::*;

    localparam int unsigned BRQ_PC_INC = 4;

    typedef struct packed {
        pc_t  pc;
        logic taken;
        pc_t  target;
    } branch_update_t;
endpackage

// File: rtl/brq_fifo.sv
// Circular update buffer: up to LANES compacted writes and one read per cycle.
// Overflow is prevented by the producer (ex_ready), so no full check here.
module brq_fifo
    import BranchResolveTypes::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned OCC_W = PTR_W + 1,
    localparam int unsigned CNT_W = $clog2(LANES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     wr_cnt,
    input  branch_update_t       wr_data [LANES],
    input  logic                 rd_en,
    output branch_update_t       rd_data,
    output logic [OCC_W-1:0]     occupancy
);
    branch_update_t   mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             deq;

    // A read request on an empty buffer is a no-op.
    assign deq = rd_en && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (CNT_W'(k) < wr_cnt) begin
                    mem[wr_ptr_q + PTR_W'(k)] <= wr_data[k];
                end
            end
            wr_ptr_q <= wr_ptr_q + PTR_W'(wr_cnt);
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + OCC_W'(wr_cnt) - OCC_W'(deq);
        end
    end

    assign rd_data   = mem[rd_ptr_q];
    assign occupancy = count_q;
endmodule

// File: rtl/branch_resolve_queue.sv
// Multi-lane branch resolution: mispredict detection, oldest-lane redirect,
// squash of younger lanes and predictor update queue. Statistics under BRQ_STATS_EN.
module branch_resolve_queue
    import BranchResolveTypes::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 32,
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      ex_valid,
    input  logic [LANES-1:0]      ex_is_branch,
    input  logic [LANES-1:0]      ex_taken,
    input  logic [LANES*PC_W-1:0] ex_pc,
    input  logic [LANES*PC_W-1:0] ex_target,
    input  logic [LANES-1:0]      ex_pred_taken,
    input  logic [LANES*PC_W-1:0] ex_pred_target,
    output logic                  ex_ready,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [PC_W-1:0]       upd_pc,
    output logic                  upd_taken,
    output logic [PC_W-1:0]       upd_target,
    output logic [OCC_W-1:0]      occupancy,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);
    import PipelineTypes::pc_t;

    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [LANES-1:0] lane_br;
    logic [LANES-1:0] lane_mis;
    logic [CNT_W-1:0] n_enq;
    logic             found;
    logic [PC_W-1:0]  redir_pc_d;
    branch_update_t   wr_data [LANES];
    branch_update_t   rd_data;

    // Readiness uses registered occupancy only; a same-cycle dequeue earns no credit.
    assign ex_ready = (OCC_W'(DEPTH) - occupancy) >= OCC_W'(LANES);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_br[i]  = ex_valid[i] & ex_is_branch[i] & ex_ready;
            lane_mis[i] = (ex_taken[i] != ex_pred_taken[i]) ||
                          (ex_taken[i] &&
                           (ex_target[i*PC_W +: PC_W] != ex_pred_target[i*PC_W +: PC_W]));
        end
    end

    // Walk lanes oldest first; once a mispredict is seen, younger lanes are squashed.
    always_comb begin
        n_enq      = '0;
        found      = 1'b0;
        redir_pc_d = '0;
        for (int k = 0; k < LANES; k++) begin
            wr_data[k] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_br[i] && !found) begin
                for (int k = 0; k < LANES; k++) begin
                    if (CNT_W'(k) == n_enq) begin
                        wr_data[k].pc     = pc_t'(ex_pc[i*PC_W +: PC_W]);
                        wr_data[k].taken  = ex_taken[i];
                        wr_data[k].target = pc_t'(ex_target[i*PC_W +: PC_W]);
                    end
                end
                n_enq = n_enq + CNT_W'(1);
                if (lane_mis[i]) begin
                    found      = 1'b1;
                    redir_pc_d = ex_taken[i] ? ex_target[i*PC_W +: PC_W]
                                             : ex_pc[i*PC_W +: PC_W] + PC_W'(BRQ_PC_INC);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= found;
            if (found) begin
                redirect_pc <= redir_pc_d;
            end
        end
    end

    brq_fifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_cnt    (n_enq),
        .wr_data   (wr_data),
        .rd_en     (upd_ready),
        .rd_data   (rd_data),
        .occupancy (occupancy)
    );

    assign upd_valid  = occupancy != '0;
    assign upd_pc     = PC_W'(rd_data.pc);
    assign upd_taken  = rd_data.taken;
    assign upd_target = PC_W'(rd_data.target);

`ifdef BRQ_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;
    logic [32:0] branch_sum;

    assign branch_sum = {1'b0, branch_cnt_q} + 33'(n_enq);

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q <= branch_sum[32] ? 32'hFFFF_FFFF : branch_sum[31:0];
            if (found && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`else
    assign branch_cnt     = '0;
    assign mispredict_cnt = '0;
`endif
endmodule
